alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one combinational ALU (3-bit ctrl: 000 add, 001 sub, 010 and, 011 or) between NREQ requesters.
//  Round-robin grant with valid/ready handshake; result and eq flag registered and returned with requester id.
//  Sits between the requesting units (e.g. branch compare, address gen) and the shared ALU instance.
// PARAMETERS
//  D_WIDTH  32  operand/result width
//  NREQ     2   number of requesters (2..8)
//  IDW      $clog2(NREQ) (min 1)  width of rsp_id; derived, not overridden
// PORTS
//  clk        in   1            clock, all logic on rising edge
//  rst        in   1            synchronous active-high reset
//  req_valid  in   NREQ         per-requester request valid
//  req_ready  out  NREQ         one-hot accept (grant) this cycle
//  req_ctrl   in   3*NREQ       packed ALU ctrl, requester i at [3i+:3]
//  req_op1    in   D_WIDTH*NREQ packed operand 1, requester i at [D_WIDTH*i+:D_WIDTH]
//  req_op2    in   D_WIDTH*NREQ packed operand 2, same packing
//  rsp_valid  out  1            registered result valid
//  rsp_ready  in   1            consumer accepts result
//  rsp_id     out  IDW          index of requester that owns rsp_data
//  rsp_data   out  D_WIDTH      registered ALU result
//  rsp_eq     out  1            registered ALU eq flag
//  alu_src    out  1            tied 0 (register operand path selected)
//  alu_ctrl   out  3            to shared ALU
//  alu_op1    out  D_WIDTH      to shared ALU
//  alu_op2    out  D_WIDTH      to shared ALU (regop2 input)
//  alu_out    in   D_WIDTH      from shared ALU
//  alu_eq     in   1            from shared ALU
// BEHAVIOUR
//  FSM: IDLE (no result held), RESP (result held, rsp_valid=1).
//  can_accept = (state==IDLE) | (state==RESP & rsp_ready).
//  Grant g: first i with req_valid[i] searching rr_ptr, rr_ptr+1, ... mod NREQ; only when can_accept.
//  req_ready[g]=1 combinationally in grant cycle; all other bits 0; req_ready=0 when !can_accept.
//  Grant cycle: alu_ctrl/op1/op2 = requester g fields; no grant -> drive all zero.
//  Edge after grant: rsp_data<=alu_out, rsp_eq<=alu_eq, rsp_id<=g, state<=RESP, rr_ptr<=(g+1)%NREQ.
//  Latency: grant cycle N -> rsp_valid in cycle N+1. Throughput 1 op/cycle when rsp_ready held high.
//  RESP & rsp_ready & no grant -> IDLE; RESP & !rsp_ready -> hold all rsp_* stable, no grant.
//  Requester must hold its fields stable while req_valid=1 and req_ready[i]=0; may drop valid freely (no lock).
//  rr_ptr unchanged on cycles without grant; wraps NREQ-1 -> 0.
//  Reset: state=IDLE, rr_ptr=0, rsp_valid=0, rsp_data=0, rsp_eq=0, rsp_id=0; reset mid-RESP drops result.
//  Ctrl codes 100..111 passed through unmodified; arbiter does not interpret opcodes.
// CONFIGURATION
//  ALU_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, rr_ptr absent (g = lowest valid).
//  Undefined (default): round-robin as above.
// STRUCTURE
//  alu_arb_pkg: typedef enum logic {IDLE,RESP} arb_state_e; ALU_ADD/SUB/AND/OR localparams (3'b000..011).
//  Sub-module rr_picker (combinational): inputs req, ptr; outputs one-hot grant + index.
//  rr_picker is instantiated in both configs; ptr tied 0 under ALU_ARB_FIXED_PRIO_EN.
// TESTING
//  Reset: rst=1 two cycles with req_valid=2'b11 -> req_ready=0, rsp_valid=0, rsp_data=0.
//  Single: req0 ctrl=000 op1=5 op2=7, rsp_ready=1 -> next cycle rsp_valid=1, data=12, eq=0, id=0.
//  Contention: req_valid=11 held 4 cycles, rsp_ready=1 -> grants 0,1,0,1 (fixed-prio: 0,0,0,0).
//  Backpressure: rsp_ready=0 after sub 9-9 -> data=0, eq=1 held 3 cycles, req_ready=0 throughout.
//  Back-to-back: req1 and(F0,3C) then or(F0,0F), rsp_ready=1 -> data 30 then FF on consecutive cycles.
//  Reset mid-RESP: rst=1 while rsp_valid=1 -> next cycle rsp_valid=0, rr_ptr=0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the ALU arbiter slice: FSM state, ALU opcodes,
// and the requester-id width helper.
package alu_arb_pkg;

  typedef enum logic {IDLE, RESP} arb_state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  // Requester id width; a single-bit id is kept even for tiny NREQ
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester/consumer side bundle of the ALU arbiter: packed per-requester request
// fields with valid/ready, plus the registered response channel.
interface alu_arbiter_if #(
  parameter int D_WIDTH = 32,
  parameter int NREQ    = 2
);
  localparam int IDW = alu_arb_pkg::id_width(NREQ);

  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [3*NREQ-1:0]       req_ctrl;
  logic [D_WIDTH*NREQ-1:0] req_op1;
  logic [D_WIDTH*NREQ-1:0] req_op2;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [IDW-1:0]          rsp_id;
  logic [D_WIDTH-1:0]      rsp_data;
  logic                    rsp_eq;

  modport master (
    output req_valid, req_ctrl, req_op1, req_op2, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_eq
  );

  modport slave (
    input  req_valid, req_ctrl, req_op1, req_op2, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_eq
  );

endinterface

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational rotating-priority picker: first set bit of req starting at ptr,
// wrapping modulo NREQ. Returns one-hot grant, its index and an any-request flag.
module rr_picker #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        idx      = IDW'(j);
        grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates NREQ requesters onto one shared combinational ALU and registers the
// result with its owner id. Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
import alu_arb_pkg::*;

module alu_arbiter #(
  parameter int D_WIDTH = 32,
  parameter int NREQ    = 2
) (
  input  logic               clk,
  input  logic               rst,
  alu_arbiter_if.slave       bus,
  output logic               alu_src,
  output logic [2:0]         alu_ctrl,
  output logic [D_WIDTH-1:0] alu_op1,
  output logic [D_WIDTH-1:0] alu_op2,
  input  logic [D_WIDTH-1:0] alu_out,
  input  logic               alu_eq
);
  localparam int IDW = id_width(NREQ);

  arb_state_e         r_state;
  logic [IDW-1:0]     r_rsp_id;
  logic [D_WIDTH-1:0] r_rsp_data;
  logic               r_rsp_eq;

  logic [NREQ-1:0]    w_onehot;
  logic [IDW-1:0]     w_idx;
  logic [IDW-1:0]     w_ptr;
  logic               w_any;
  logic               w_can_accept;
  logic               w_grant;

  logic [2:0]         w_ctrl [NREQ];
  logic [D_WIDTH-1:0] w_op1  [NREQ];
  logic [D_WIDTH-1:0] w_op2  [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_ctrl[gi] = bus.req_ctrl[3*gi +: 3];
      assign w_op1[gi]  = bus.req_op1[D_WIDTH*gi +: D_WIDTH];
      assign w_op2[gi]  = bus.req_op2[D_WIDTH*gi +: D_WIDTH];
    end
  endgenerate

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [IDW-1:0] r_rr_ptr;

  assign w_ptr = r_rr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      r_rr_ptr <= (w_idx == IDW'(NREQ-1)) ? '0 : w_idx + 1'b1;
    end
  end
`endif

  rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_picker (
    .req   (bus.req_valid),
    .ptr   (w_ptr),
    .grant (w_onehot),
    .idx   (w_idx),
    .any   (w_any)
  );

  // No grant while in reset, otherwise the accepted operation would be lost
  assign w_can_accept  = !rst && ((r_state == IDLE) || bus.rsp_ready);
  assign w_grant       = w_can_accept && w_any;
  assign bus.req_ready = w_grant ? w_onehot : '0;

  assign alu_src  = 1'b0;
  assign alu_ctrl = w_grant ? w_ctrl[w_idx] : '0;
  assign alu_op1  = w_grant ? w_op1[w_idx]  : '0;
  assign alu_op2  = w_grant ? w_op2[w_idx]  : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rsp_id   <= '0;
      r_rsp_data <= '0;
      r_rsp_eq   <= 1'b0;
    end else if (w_grant) begin
      r_state    <= RESP;
      r_rsp_id   <= w_idx;
      r_rsp_data <= alu_out;
      r_rsp_eq   <= alu_eq;
    end else if (r_state == RESP && bus.rsp_ready) begin
      r_state    <= IDLE;
    end
  end

  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_eq    = r_rsp_eq;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
import alu_arb_pkg::*;

module tb_alu_arbiter;
  localparam int DW  = 32;
  localparam int NR  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_src;
  logic [2:0]    alu_ctrl;
  logic [DW-1:0] alu_op1, alu_op2, alu_out;
  logic          alu_eq;

  logic [NR-1:0] t_valid;
  logic          t_rsp_ready;
  logic [2:0]    t_ctrl [NR];
  logic [DW-1:0] t_op1  [NR];
  logic [DW-1:0] t_op2  [NR];

  int n_checks = 0;
  int n_errors = 0;

  alu_arbiter_if #(.D_WIDTH(DW), .NREQ(NR)) bus ();

  alu_arbiter #(.D_WIDTH(DW), .NREQ(NR)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .alu_src  (alu_src),
    .alu_ctrl (alu_ctrl),
    .alu_op1  (alu_op1),
    .alu_op2  (alu_op2),
    .alu_out  (alu_out),
    .alu_eq   (alu_eq)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_fn(input logic [2:0] c, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    case (c)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      3'b100:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  // Stand-in for the shared ALU
  assign alu_out = alu_fn(alu_ctrl, alu_op1, alu_op2);
  assign alu_eq  = (alu_op1 == alu_op2);

  always_comb begin
    bus.req_ctrl  = '0;
    bus.req_op1   = '0;
    bus.req_op2   = '0;
    bus.req_valid = t_valid;
    bus.rsp_ready = t_rsp_ready;
    for (int i = 0; i < NR; i++) begin
      bus.req_ctrl[3*i +: 3]  = t_ctrl[i];
      bus.req_op1[DW*i +: DW] = t_op1[i];
      bus.req_op2[DW*i +: DW] = t_op2[i];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit            m_init = 0;
  bit            m_held;
  logic [DW-1:0] m_data;
  bit            m_eq;
  int            m_id;
  int            m_ptr;

  function automatic int pick(input logic [NR-1:0] v, input int ptr);
    int p;
`ifdef ALU_ARB_FIXED_PRIO_EN
    p = 0;
`else
    p = ptr;
`endif
    for (int k = 0; k < NR; k++)
      if (v[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  function automatic int model_grant();
    if (rst || (m_held && !t_rsp_ready)) return -1;
    return pick(t_valid, m_ptr);
  endfunction

  always @(posedge clk) begin
    int g;
    if (rst) begin
      m_init = 1;
      m_held = 0;
      m_data = '0;
      m_eq   = 0;
      m_id   = 0;
      m_ptr  = 0;
    end else if (m_init) begin
      g = model_grant();
      if (g >= 0) begin
        m_data = alu_fn(t_ctrl[g], t_op1[g], t_op2[g]);
        m_eq   = (t_op1[g] == t_op2[g]);
        m_id   = g;
        m_held = 1;
        m_ptr  = (g + 1) % NR;
      end else if (m_held && t_rsp_ready) begin
        m_held = 0;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    if (m_init) begin
      g = model_grant();
      chk("req_ready", 64'(bus.req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_held));
      chk("rsp_data",  64'(bus.rsp_data),  64'(m_data));
      chk("rsp_eq",    64'(bus.rsp_eq),    64'(m_eq));
      chk("rsp_id",    64'(bus.rsp_id),    64'(m_id));
      chk("alu_ctrl",  64'(alu_ctrl), (g >= 0) ? 64'(t_ctrl[g]) : 64'd0);
      chk("alu_op1",   64'(alu_op1),  (g >= 0) ? 64'(t_op1[g])  : 64'd0);
      chk("alu_op2",   64'(alu_op2),  (g >= 0) ? 64'(t_op2[g])  : 64'd0);
      chk("alu_src",   64'(alu_src),  64'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] c, input logic [DW-1:0] a,
                         input logic [DW-1:0] b);
    t_ctrl[i] = c;
    t_op1[i]  = a;
    t_op2[i]  = b;
  endtask

  initial begin
    logic [NR-1:0] exp_grants [4];
    logic [NR-1:0] last_ready;
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_grants = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_grants = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    rst = 1'b1;
    t_valid = 2'b11;
    t_rsp_ready = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 3'b000, '0, '0);

    // Reset held two cycles with both requesters asking
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_rsp_data",  64'(bus.rsp_data),  64'd0);
    end
    step();
    rst = 1'b0;
    t_valid = '0;

    // Single add
    step();
    set_req(0, ALU_ADD, 32'd5, 32'd7);
    t_valid = 2'b01;
    t_rsp_ready = 1'b1;
    @(negedge clk);
    chk("single_ready", 64'(bus.req_ready), 64'd1);
    step();
    t_valid = '0;
    @(negedge clk);
    chk("single_valid", 64'(bus.rsp_valid), 64'd1);
    chk("single_data",  64'(bus.rsp_data),  64'd12);
    chk("single_eq",    64'(bus.rsp_eq),    64'd0);
    chk("single_id",    64'(bus.rsp_id),    64'd0);

    // Contention from a fresh pointer
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, ALU_ADD, 32'd1, 32'd2);
    set_req(1, ALU_ADD, 32'd3, 32'd4);
    t_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("contend_grant", 64'(bus.req_ready), 64'(exp_grants[i]));
      step();
    end
    t_valid = '0;

    // Backpressure after sub 9-9
    set_req(0, ALU_SUB, 32'd9, 32'd9);
    t_valid = 2'b01;
    @(negedge clk);
    chk("bp_grant", 64'(bus.req_ready), 64'd1);
    step();
    t_valid = 2'b11;
    t_rsp_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("bp_data",  64'(bus.rsp_data),  64'd0);
      chk("bp_eq",    64'(bus.rsp_eq),    64'd1);
      chk("bp_ready", 64'(bus.req_ready), 64'd0);
      step();
    end
    t_valid = '0;
    t_rsp_ready = 1'b1;
    step();

    // Back-to-back from requester 1
    set_req(1, ALU_AND, 32'hF0, 32'h3C);
    t_valid = 2'b10;
    @(negedge clk);
    chk("b2b_grant", 64'(bus.req_ready), 64'd2);
    step();
    set_req(1, ALU_OR, 32'hF0, 32'h0F);
    @(negedge clk);
    chk("b2b_data0", 64'(bus.rsp_data),  64'h30);
    chk("b2b_grant", 64'(bus.req_ready), 64'd2);
    step();
    t_valid = '0;
    @(negedge clk);
    chk("b2b_data1", 64'(bus.rsp_data),  64'hFF);
    chk("b2b_id",    64'(bus.rsp_id),    64'd1);
    step();

    // Reset while a result is held; pointer must restart at 0
    t_rsp_ready = 1'b0;
    set_req(0, ALU_ADD, 32'd1, 32'd1);
    t_valid = 2'b01;
    step();
    t_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_held", 64'(bus.rsp_valid), 64'd1);
    step();
    rst = 1'b0;
    t_valid = 2'b11;
    t_rsp_ready = 1'b1;
    @(negedge clk);
    chk("mid_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mid_ptr",   64'(bus.req_ready), 64'd1);
    step();
    t_valid = '0;

    // Randomized traffic; a pending requester keeps its fields stable
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      last_ready = bus.req_ready;
      step();
      rst = ($urandom_range(0, 63) == 0);
      t_rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NR; i++) begin
        if (!(t_valid[i] && !last_ready[i])) begin
          t_valid[i] = ($urandom_range(0, 2) != 0);
          t_ctrl[i]  = 3'($urandom_range(0, 7));
          if ($urandom_range(0, 1) == 1) begin
            t_op1[i] = DW'($urandom_range(0, 3));
            t_op2[i] = DW'($urandom_range(0, 3));
          end else begin
            t_op1[i] = $urandom;
            t_op2[i] = $urandom;
          end
        end
      end
    end
    rst = 1'b0;
    t_valid = '0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
